soc_addr_decoder: RTL
=====================

# soc_addr_decoder

Registered, runtime-reprogrammable address decoder that maps an incoming bus address to a slave index of the SoC crossbar. It generalises the static SoC address map to a parametrised rule table of `NrRules` entries. Each entry has a base, a length and an enable. Entries can be rewritten at run time until software locks them. The block sits in front of the crossbar's address channel, with a one-entry valid/ready output pipeline.

## Interface
- `AddrWidth`, default 64: address width.
- `NrRules`, default 11: number of rule entries; entry i decodes to slave index i.
- `RuleBase`, default is the SoC map bases (DRAM 0x8000_0000 … Debug 0x0): per-entry reset base, `[NrRules-1:0][AddrWidth-1:0]`.
- `RuleLen`, default is the SoC map lengths: per-entry reset length; a length of 0 means the entry never matches.
- `DefaultEn`, default 0: an unmatched address routes to `DefaultIdx` instead of flagging an error.
- `DefaultIdx`, default 0: fallback index.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `req_valid_i`  in  1  address valid.
- `req_ready_o`  out  1  address accepted.
- `req_addr_i`  in  AddrWidth  address to decode.
- `rsp_valid_o`  out  1  decode result valid.
- `rsp_ready_i`  in  1  downstream accepts result.
- `rsp_addr_o`  out  AddrWidth  registered copy of the address.
- `rsp_idx_o`  out  $clog2(NrRules)  matched slave index.
- `rsp_err_o`  out  1  no match (decode error).
- `cfg_we_i`  in  1  rule write strobe.
- `cfg_rule_i`  in  $clog2(NrRules)  rule to write.
- `cfg_base_i`, `cfg_len_i`  in  AddrWidth  new base and new length.
- `cfg_en_i`  in  1  new enable.
- `cfg_lock_i`  in  1  set the sticky table lock.
- `cfg_err_o`  out  1  one-cycle pulse: write rejected.
- `locked_o`  out  1  table lock state.
- `miss_cnt_o`  out  32  decode-miss counter; present only with `ADDR_DECODE_STATS_EN`.

## Operation
- Rule table reset state: entry i = {`RuleBase[i]`, `RuleLen[i]`, enable = 1}.
- Match rule for entry i: enabled, len ≠ 0, and base ≤ addr < base + len.
  - The sum base + len is computed at AddrWidth+1 bits, so the upper bound cannot wrap.
  - An entry ending exactly at 2^AddrWidth is legal.
- Overlapping entries: the lowest matching index wins.
- No match with `DefaultEn`=1: `rsp_idx_o`=`DefaultIdx`, `rsp_err_o`=0.
- No match with `DefaultEn`=0: `rsp_idx_o`=0, `rsp_err_o`=1.
- Output register has two states:
  - EMPTY → FULL on request accept.
  - FULL → EMPTY on `rsp_ready_i` with no new accept.
  - FULL → FULL on a simultaneous consume and accept.
- `req_ready_o` = !`rsp_valid_o` || `rsp_ready_i` (combinational). An address is accepted when `req_valid_i` && `req_ready_o`.
- While `rsp_valid_o`=1 and `rsp_ready_i`=0, all `rsp_*` outputs hold stable.
- Config write, when unlocked and `cfg_rule_i` < `NrRules`: the entry updates at the clock edge.
- A request accepted in the same cycle as a write decodes against the old table.
- `cfg_lock_i`=1 sets the lock at the next edge. The lock is cleared only by `rst_i`.
- A write with `cfg_lock_i` in the same cycle, issued while still unlocked, is applied.
- `cfg_err_o` pulses for one cycle after `cfg_we_i` when:
  - the table is locked, or
  - `cfg_rule_i` ≥ `NrRules`.
  The table is unchanged in both cases.

## Timing
- Decode latency: the result is visible 1 cycle after acceptance. Throughput is 1 decode per cycle when `rsp_ready_i`=1.
- Reset (async assert, sync release):
  - `rsp_valid_o`=0, `rsp_idx_o`=0, `rsp_err_o`=0, `rsp_addr_o`=0.
  - `cfg_err_o`=0, `locked_o`=0, `miss_cnt_o`=0.
  - Table reloads its parameter values.
- Reset mid-transaction drops the pending result; there is no partial output.
- `cfg_err_o` and the lock update are registered, 1 cycle after the strobe.

## Configuration
- `ADDR_DECODE_STATS_EN` defined: `miss_cnt_o` exists.
  - Increments by 1 on each accepted request that matched no enabled entry, including default-routed misses.
  - Saturates at 0xFFFF_FFFF. Cleared only by reset.
- `ADDR_DECODE_STATS_EN` undefined: the port and counter logic are absent. All other behaviour is identical.

## Test plan
- Reset defaults, addresses 0x8000_0000, 0x1000_0010, 0x0000_0FFF, 0xBFFF_FFFF → idx 0, 5, 10, 0, err 0. 0xC000_0000 → err 1.
- Backpressure: `rsp_ready_i`=0 for 3 cycles after 0x2000_0000 → `req_ready_o`=0, `rsp_idx_o`=3 held; release → next address is accepted the same cycle.
- Rewrite: entry 5 to base 0x5000_0000, len 0x100, plus a same-cycle request to 0x1000_0000 → that request gives idx 5. Next request to 0x1000_0000 → err 1; 0x5000_00FF → idx 5; 0x5000_0100 → err 1.
- Lock: assert `cfg_lock_i`, then write entry 0 → `cfg_err_o` pulses once, DRAM decode unchanged, `locked_o`=1 until reset. A write to rule 11 while unlocked → `cfg_err_o`.
- Edge cases:
  - Overlap: entry 2 base 0x1000_0000, len 0x1000 → 0x1000_0000 decodes idx 2.
  - Top-of-space entry: base 2^64−0x1000, len 0x1000 → 0xFFFF_FFFF_FFFF_FFFF matches.
  - len=0 never matches.
- With `ADDR_DECODE_STATS_EN` and `DefaultEn`=1: 5 misses → idx `DefaultIdx`, err 0, `miss_cnt_o`=5. Async reset mid-stream → `rsp_valid_o`=0 and `miss_cnt_o`=0 immediately.

Source files
------------

// File: rtl/soc_addr_decoder_if.sv
// soc_addr_decoder_if: address channel in front of the crossbar.
//   req_*  : address in (valid/ready), decoded by soc_addr_decoder
//   rsp_*  : registered decode result out (valid/ready)
// Modports: master = address source / result sink, slave = the decoder.
interface soc_addr_decoder_if #(
   parameter int unsigned AddrWidth = 64,
   parameter int unsigned IdxW      = 4
) ();
   logic                 req_valid_i;
   logic                 req_ready_o;
   logic [AddrWidth-1:0] req_addr_i;
   logic                 rsp_valid_o;
   logic                 rsp_ready_i;
   logic [AddrWidth-1:0] rsp_addr_o;
   logic [IdxW-1:0]      rsp_idx_o;
   logic                 rsp_err_o;

   modport master (
      output req_valid_i, req_addr_i, rsp_ready_i,
      input  req_ready_o, rsp_valid_o, rsp_addr_o, rsp_idx_o, rsp_err_o
   );

   modport slave (
      input  req_valid_i, req_addr_i, rsp_ready_i,
      output req_ready_o, rsp_valid_o, rsp_addr_o, rsp_idx_o, rsp_err_o
   );
endinterface

// File: rtl/soc_addr_decoder.sv
// soc_addr_decoder: registered, runtime-reprogrammable address decoder.
// Maps req_addr to a slave index through a table of NrRules {base,len,en}
// entries (lowest matching index wins) and presents the result through a
// one-entry valid/ready output register.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   bus (slave)       req_valid/ready/addr in, rsp_valid/ready/addr/idx/err out
//   cfg_we_i, cfg_rule_i, cfg_base_i, cfg_len_i, cfg_en_i   rule write
//   cfg_lock_i        set sticky table lock (cleared only by reset)
//   cfg_err_o         one-cycle pulse: write rejected (locked / bad rule)
//   locked_o          lock state
//   miss_cnt_o        saturating decode-miss counter, only when the macro
//                     ADDR_DECODE_STATS_EN is defined
module soc_addr_decoder #(
   parameter int unsigned AddrWidth = 64,
   parameter int unsigned NrRules   = 11,
   // Default SoC map, entry 0 (DRAM) in the low word up to entry 10 (Debug)
   parameter logic [NrRules-1:0][AddrWidth-1:0] RuleBase = {
      64'h0000_0000,   // 10 Debug
      64'h0100_0000,   //  9 SRAM
      64'h0001_0000,   //  8 ROM
      64'h0200_0000,   //  7 CLINT
      64'h0C00_0000,   //  6 PLIC
      64'h1000_0000,   //  5 UART
      64'h1800_0000,   //  4 Timer
      64'h2000_0000,   //  3 SPI
      64'h3000_0000,   //  2 Ethernet
      64'h4000_0000,   //  1 GPIO
      64'h8000_0000},  //  0 DRAM
   parameter logic [NrRules-1:0][AddrWidth-1:0] RuleLen = {
      64'h0000_1000,
      64'h0001_0000,
      64'h0001_0000,
      64'h000C_0000,
      64'h03FF_FFFF,
      64'h0000_1000,
      64'h0000_1000,
      64'h0080_0000,
      64'h0001_0000,
      64'h0000_1000,
      64'h4000_0000},
   parameter bit          DefaultEn  = 1'b0,
   parameter int unsigned DefaultIdx = 0,
   localparam int unsigned IdxW = (NrRules > 1) ? $clog2(NrRules) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   soc_addr_decoder_if.slave    bus,
   input  logic                 cfg_we_i,
   input  logic [IdxW-1:0]      cfg_rule_i,
   input  logic [AddrWidth-1:0] cfg_base_i,
   input  logic [AddrWidth-1:0] cfg_len_i,
   input  logic                 cfg_en_i,
   input  logic                 cfg_lock_i,
   output logic                 cfg_err_o,
   output logic                 locked_o
`ifdef ADDR_DECODE_STATS_EN
   ,
   output logic [31:0]          miss_cnt_o
`endif
);

   typedef enum logic {EMPTY, FULL} state_e;

   state_e                             state_q, state_d;
   logic [AddrWidth-1:0]               rsp_addr_q, rsp_addr_d;
   logic [IdxW-1:0]                    rsp_idx_q, rsp_idx_d;
   logic                               rsp_err_q, rsp_err_d;
   logic [NrRules-1:0][AddrWidth-1:0]  base_q, base_d, len_q, len_d;
   logic [NrRules-1:0]                 en_q, en_d;
   logic                               locked_q, locked_d;
   logic                               cfg_err_q, cfg_err_d;

   logic                               accept, rule_ok, wr_ok;
   logic [NrRules-1:0]                 hit;
   logic [IdxW-1:0]                    dec_idx;
   logic                               dec_miss, dec_err;

   assign bus.req_ready_o = (state_q == EMPTY) || bus.rsp_ready_i;
   assign accept          = bus.req_valid_i && bus.req_ready_o;

   // Upper bound carried at AddrWidth+1 bits so an entry may end exactly
   // at the top of the address space without wrapping to zero.
   for (genvar g = 0; g < NrRules; g++) begin : g_rule
      logic [AddrWidth:0] lim;
      assign lim    = {1'b0, base_q[g]} + {1'b0, len_q[g]};
      assign hit[g] = en_q[g] && (len_q[g] != '0) &&
                      (bus.req_addr_i >= base_q[g]) &&
                      ({1'b0, bus.req_addr_i} < lim);
   end

   // Scan high to low so the lowest matching index is the last writer.
   always_comb begin
      dec_idx  = '0;
      for (int i = NrRules - 1; i >= 0; i--) begin
         if (hit[i]) dec_idx = IdxW'(i);
      end
      dec_miss = ~|hit;
      dec_err  = dec_miss && !DefaultEn;
      if (dec_miss && DefaultEn) dec_idx = IdxW'(DefaultIdx);
   end

   // Output register: data loads on accept, valid drops on consume only.
   always_comb begin
      state_d    = state_q;
      rsp_addr_d = rsp_addr_q;
      rsp_idx_d  = rsp_idx_q;
      rsp_err_d  = rsp_err_q;
      if (accept) begin
         state_d    = FULL;
         rsp_addr_d = bus.req_addr_i;
         rsp_idx_d  = dec_idx;
         rsp_err_d  = dec_err;
      end else if (bus.rsp_ready_i) begin
         state_d    = EMPTY;
      end
   end

   // Rule table update; the decode above always sees the pre-write table.
   assign rule_ok = 32'(cfg_rule_i) < NrRules;
   assign wr_ok   = cfg_we_i && !locked_q && rule_ok;

   always_comb begin
      base_d    = base_q;
      len_d     = len_q;
      en_d      = en_q;
      if (wr_ok) begin
         base_d[cfg_rule_i] = cfg_base_i;
         len_d[cfg_rule_i]  = cfg_len_i;
         en_d[cfg_rule_i]   = cfg_en_i;
      end
      locked_d  = locked_q || cfg_lock_i;
      cfg_err_d = cfg_we_i && (locked_q || !rule_ok);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= EMPTY;
         rsp_addr_q <= '0;
         rsp_idx_q  <= '0;
         rsp_err_q  <= 1'b0;
         base_q     <= RuleBase;
         len_q      <= RuleLen;
         en_q       <= '1;
         locked_q   <= 1'b0;
         cfg_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rsp_addr_q <= rsp_addr_d;
         rsp_idx_q  <= rsp_idx_d;
         rsp_err_q  <= rsp_err_d;
         base_q     <= base_d;
         len_q      <= len_d;
         en_q       <= en_d;
         locked_q   <= locked_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

   assign bus.rsp_valid_o = (state_q == FULL);
   assign bus.rsp_addr_o  = rsp_addr_q;
   assign bus.rsp_idx_o   = rsp_idx_q;
   assign bus.rsp_err_o   = rsp_err_q;
   assign cfg_err_o       = cfg_err_q;
   assign locked_o        = locked_q;

`ifdef ADDR_DECODE_STATS_EN
   // Counts every accepted miss, default-routed ones included; saturates.
   logic [31:0] miss_cnt_q, miss_cnt_d;

   always_comb begin
      miss_cnt_d = miss_cnt_q;
      if (accept && dec_miss && (miss_cnt_q != 32'hFFFF_FFFF))
         miss_cnt_d = miss_cnt_q + 32'd1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) miss_cnt_q <= '0;
      else       miss_cnt_q <= miss_cnt_d;
   end

   assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
